// File: rtl/spi_pkg.sv
// Shared register-map constants, status bit positions and FSM state type
// for the SPI slave.
package spi_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_CTRL = 2'b10;
  localparam logic [1:0] ADDR_RSVD = 2'b11;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_OVERRUN  = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, plus a one-cycle
// delayed copy of the synchronized level for edge detection.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic dout_d
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      dout_d <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dout_d <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with 8-bit frames, MSB first, oversampled on clk, plus a
// small host register interface for tx/rx bytes and status.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic       cs,
  output logic [7:0] out_data,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso
);

  logic sclk_s, sclk_d, mosi_s, mosi_dly_unused, ss_s, ss_d;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s), .dout_d(sclk_d));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s), .dout_d(mosi_dly_unused));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(ss_n), .dout(ss_s), .dout_d(ss_d));

  spi_state_e state, state_nxt;
  logic       start, abort;
  logic [7:0] tx_buf, tx_shift, tx_shift_nxt, rx_shift, rx_data;
  logic [2:0] bit_cnt;
  logic       tx_full, rx_valid, overrun, reload_pend;

  logic sclk_rise, sclk_fall, ss_fall, running;
  logic rx_step, tx_step, byte_done, reload;
  logic wr_data, wr_ovr_clr, rd_data, rd_any;

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    unique case (state)
      ST_IDLE:   if (ss_fall) begin state_nxt = ST_ACTIVE; start = 1'b1; end
      ST_ACTIVE: if (ss_s)    begin state_nxt = ST_IDLE;   abort = 1'b1; end
    endcase
  end

  // sclk edges only count while the frame is live; a deselect wins any tie.
  assign running   = (state == ST_ACTIVE) && !ss_s;
  assign rx_step   = running && sclk_rise;
  assign tx_step   = running && sclk_fall;
  assign byte_done = rx_step && (bit_cnt == 3'd7);
  assign reload    = start || (tx_step && reload_pend);

  assign wr_data    = cs && wr && (addr == ADDR_DATA);
  assign wr_ovr_clr = cs && wr && (addr == ADDR_CTRL) && in_data[0];
  assign rd_data    = cs && rd && (addr == ADDR_DATA);
  assign rd_any     = cs && rd;

  always_comb begin
    tx_shift_nxt = tx_shift;
    if (reload)       tx_shift_nxt = tx_full ? tx_buf : 8'h00;
    else if (tx_step) tx_shift_nxt = {tx_shift[6:0], 1'b0};
  end

  // NOTE: the whole datapath resets here; these are plain registers, not
  // memories, so clearing them asynchronously costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift    <= 8'h00;
      miso        <= 1'b0;
      rx_shift    <= 8'h00;
      bit_cnt     <= 3'd0;
      reload_pend <= 1'b0;
    end else begin
      tx_shift <= tx_shift_nxt;
      miso     <= (state_nxt == ST_ACTIVE) ? tx_shift_nxt[7] : 1'b0;
      if (start || abort) begin
        bit_cnt     <= 3'd0;
        reload_pend <= 1'b0;
      end else begin
        if (rx_step) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (byte_done)    reload_pend <= 1'b1;
        else if (tx_step) reload_pend <= 1'b0;
      end
    end
  end

  // Host side: set events beat same-cycle clears so no byte is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf   <= 8'h00;
      tx_full  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      out_data <= 8'h00;
    end else begin
      if (wr_data) tx_buf <= in_data;
      if (wr_data)     tx_full <= 1'b1;
      else if (reload) tx_full <= 1'b0;

      if (byte_done) rx_data <= {rx_shift[6:0], mosi_s};
      if (byte_done)    rx_valid <= 1'b1;
      else if (rd_data) rx_valid <= 1'b0;

      if (byte_done && rx_valid && !rd_data) overrun <= 1'b1;
      else if (wr_ovr_clr)                   overrun <= 1'b0;

      if (rd_any) begin
        unique case (addr)
          ADDR_DATA: out_data <= rx_data;
          ADDR_STAT: begin
            out_data                <= 8'h00;
            out_data[STAT_RX_VALID] <= rx_valid;
            out_data[STAT_TX_FULL]  <= tx_full;
            out_data[STAT_OVERRUN]  <= overrun;
          end
          ADDR_CTRL: out_data <= tx_buf;
          ADDR_RSVD: out_data <= 8'h00;
        endcase
      end
    end
  end

endmodule
